// File: rtl/mem_burst_reader.sv
// Burst read initiator for a fixed-latency memory read port: issues credit-limited
// single-word reads and streams the returned words downstream with a last flag.
module mem_burst_reader #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_LAT   = 2,
  parameter int LEN_WIDTH  = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [LEN_WIDTH-1:0]  cmd_len,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic                  r_avalid,
  input  logic                  r_dvalid,
  input  logic [DATA_WIDTH-1:0] r_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_last,
  output logic                  busy,
  output logic                  protocol_err
);

  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W:0]   CREDIT_LIM = (CNT_W + 1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic [ADDR_WIDTH-1:0] r_cur_addr;
  logic [LEN_WIDTH-1:0]  r_remaining;
  logic [CNT_W-1:0]      r_inflight;
  logic [CNT_W-1:0]      r_fifo_cnt;
  logic [PTR_W-1:0]      r_wr_ptr;
  logic [PTR_W-1:0]      r_rd_ptr;
  logic [DATA_LAT-1:0]   r_tag_pipe;
  logic                  r_protocol_err;
  logic [DATA_WIDTH-1:0] r_fifo_data [FIFO_DEPTH];
  logic                  r_fifo_last [FIFO_DEPTH];

  logic [CNT_W:0] w_credit_sum;
  logic           w_credit_ok;
  logic           w_cmd_fire;
  logic           w_issue;
  logic           w_issue_last;
  logic           w_push;
  logic           w_pop;
  logic           w_stray;
  logic           w_full;

  // Everything already buffered or still in the memory pipeline holds a FIFO slot.
  assign w_credit_sum = {1'b0, r_fifo_cnt} + {1'b0, r_inflight};
  assign w_credit_ok  = w_credit_sum < CREDIT_LIM;
  assign w_cmd_fire   = cmd_valid && cmd_ready;
  assign w_issue      = r_avalid;
  assign w_issue_last = w_issue && (r_remaining == '0);
  assign w_push       = r_dvalid && (r_inflight != '0);
  assign w_stray      = r_dvalid && (r_inflight == '0);
  assign w_pop        = out_valid && out_ready;
  assign w_full       = (r_fifo_cnt == FULL_CNT);

  assign r_addr       = r_cur_addr;
  assign out_valid    = (r_fifo_cnt != '0);
  assign out_data     = out_valid ? r_fifo_data[r_rd_ptr] : '0;
  assign out_last     = out_valid && r_fifo_last[r_rd_ptr];
  assign protocol_err = r_protocol_err;

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (cmd_valid)          w_state_nxt = S_ISSUE;
      S_ISSUE: if (w_issue_last)       w_state_nxt = S_DRAIN;
      S_DRAIN: if (w_pop && out_last) w_state_nxt = S_IDLE;
      default:                         w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = 1'b0;
    r_avalid  = 1'b0;
    busy      = 1'b1;
    unique case (r_state)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      S_ISSUE: r_avalid = w_credit_ok;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cur_addr     <= '0;
      r_remaining    <= '0;
      r_inflight     <= '0;
      r_fifo_cnt     <= '0;
      r_wr_ptr       <= '0;
      r_rd_ptr       <= '0;
      r_tag_pipe     <= '0;
      r_protocol_err <= 1'b0;
    end else begin
      if (w_cmd_fire) begin
        r_cur_addr  <= cmd_addr;
        r_remaining <= cmd_len;
      end else if (w_issue) begin
        r_cur_addr  <= r_cur_addr + 1'b1;
        r_remaining <= r_remaining - 1'b1;
      end

      unique case ({w_issue, w_push})
        2'b10:   r_inflight <= r_inflight + 1'b1;
        2'b01:   r_inflight <= r_inflight - 1'b1;
        default: ;
      endcase

      unique case ({w_push, w_pop})
        2'b10:   r_fifo_cnt <= r_fifo_cnt + 1'b1;
        2'b01:   r_fifo_cnt <= r_fifo_cnt - 1'b1;
        default: ;
      endcase

      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;

      // The last tag travels alongside the read so it meets its data word at push time.
      r_tag_pipe[0] <= w_issue_last;
      for (int i = 1; i < DATA_LAT; i++) r_tag_pipe[i] <= r_tag_pipe[i-1];

      if (w_stray) r_protocol_err <= 1'b1;
    end
  end

  // NOTE: payload storage is left unreset; validity comes from the count and the head mux is gated.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_data[r_wr_ptr] <= r_data;
      r_fifo_last[r_wr_ptr] <= r_tag_pipe[DATA_LAT-1];
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst) !(w_push && w_full));

endmodule

// File: tb/tb_mem_burst_reader.sv
// Self-checking bench for mem_burst_reader: a fixed-latency memory responder plus a
// queue-based reference of each burst's expected words, address sequence and timing.
module tb_mem_burst_reader;

  localparam int DW    = 32;
  localparam int AW    = 4;
  localparam int LAT   = 2;
  localparam int LW    = 4;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic [AW-1:0] r_addr;
  logic          r_avalid;
  logic          r_dvalid;
  logic [DW-1:0] r_data;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic          out_last;
  logic          busy;
  logic          protocol_err;

  logic [DW-1:0] mem [16];
  logic          mem_dv;
  logic [DW-1:0] mem_dout;
  logic          force_dv;

  int checks = 0;
  int errors = 0;

  assign r_dvalid = mem_dv | force_dv;
  assign r_data   = mem_dout;

  mem_burst_reader #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DATA_LAT(LAT), .LEN_WIDTH(LW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .r_addr(r_addr), .r_avalid(r_avalid), .r_dvalid(r_dvalid), .r_data(r_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .protocol_err(protocol_err)
  );

  always #5 clk = ~clk;

  // Memory responder: a read strobed at edge N returns LAT cycles later; shares rst.
  initial begin : mem_model
    logic          req;
    logic          rs;
    logic [AW-1:0] a;
    logic          pv [LAT];
    logic [AW-1:0] pa [LAT];
    mem_dv   = 1'b0;
    mem_dout = '0;
    for (int i = 0; i < LAT; i++) begin
      pv[i] = 1'b0;
      pa[i] = '0;
    end
    forever begin
      @(posedge clk);
      req = r_avalid;
      a   = r_addr;
      rs  = rst;
      #1;
      for (int i = LAT - 1; i > 0; i--) begin
        pv[i] = pv[i-1];
        pa[i] = pa[i-1];
      end
      pv[0] = req;
      pa[0] = a;
      if (rs) for (int i = 0; i < LAT; i++) pv[i] = 1'b0;
      mem_dv   = pv[LAT-1];
      mem_dout = mem[pa[LAT-1]];
    end
  end

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "simulation did not finish");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_cmd_ready"}, 64'(cmd_ready), 64'(1));
    check({tag, "_r_avalid"},  64'(r_avalid),  64'(0));
    check({tag, "_r_addr"},    64'(r_addr),    64'(0));
    check({tag, "_out_valid"}, 64'(out_valid), 64'(0));
    check({tag, "_out_last"},  64'(out_last),  64'(0));
    check({tag, "_out_data"},  64'(out_data),  64'(0));
    check({tag, "_busy"},      64'(busy),      64'(0));
    check({tag, "_perr"},      64'(protocol_err), 64'(0));
  endtask

  // Runs one burst; expected words, order, last flag and address sequence come from mem[].
  // When ready is always high, first/last output cycles are checked against the ideal pipeline.
  task automatic run_burst(input logic [AW-1:0] addr, input logic [LW-1:0] len,
                           input int ready_pct, input int stall);
    logic [DW:0]   exp_q [$];
    logic [DW:0]   e;
    logic [AW-1:0] ai;
    logic [AW-1:0] exp_addr;
    int n, cyc, w, issued, popped, first_out, last_out, cap;
    bit timed;
    n     = int'(len);
    timed = (ready_pct >= 100) && (stall == 0);
    for (int i = 0; i <= n; i++) begin
      ai = addr + AW'(i);
      exp_q.push_back({(i == n), mem[ai]});
    end
    w = 0;
    while (!cmd_ready && w < 50) begin
      @(negedge clk);
      w++;
    end
    check("cmd_ready_before", 64'(cmd_ready), 64'(1));
    cmd_valid = 1'b1;
    cmd_addr  = addr;
    cmd_len   = len;
    @(negedge clk);
    cmd_valid = 1'b0;
    cyc = 1;
    check("busy_after_accept", 64'(busy), 64'(1));
    issued = 0; popped = 0; first_out = -1; last_out = -1;
    exp_addr = addr;
    while (popped <= n && cyc < 300) begin
      check("cmd_ready_in_burst", 64'(cmd_ready), 64'(0));
      if (r_avalid) begin
        check("issue_addr", 64'(r_addr), 64'(exp_addr));
        exp_addr = exp_addr + 1'b1;
        issued++;
        if (timed && issued == 1) check("first_issue_cycle", 64'(cyc), 64'(1));
      end
      if (stall > 0 && cyc == stall) begin
        cap = (n + 1 < DEPTH) ? n + 1 : DEPTH;
        check("bp_issue_cap", 64'(issued), 64'(cap));
      end
      out_ready = (cyc > stall) && (int'($urandom_range(99)) < ready_pct);
      if (out_valid && out_ready) begin
        e = exp_q.pop_front();
        check("out_data", 64'(out_data), 64'(e[DW-1:0]));
        check("out_last", 64'(out_last), 64'(e[DW]));
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
        popped++;
      end
      @(negedge clk);
      cyc++;
    end
    check("burst_words", 64'(popped), 64'(n + 1));
    check("issue_count", 64'(issued), 64'(n + 1));
    if (timed) begin
      check("first_out_cycle", 64'(first_out), 64'(2 + LAT));
      check("last_out_cycle",  64'(last_out),  64'(2 + LAT + n));
    end
    check("cmd_ready_after", 64'(cmd_ready), 64'(1));
    check("busy_after",      64'(busy),      64'(0));
    check("out_valid_after", 64'(out_valid), 64'(0));
  endtask

  initial begin : stimulus
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    out_ready = 1'b0;
    force_dv  = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    mem[5] = 32'hA5A5_A5A5;
    for (int i = 0; i < 4; i++) mem[i] = 32'h100 + i;

    do_reset();
    check_idle("reset");

    // Single word, streaming, backpressure and address wrap.
    run_burst(4'd5, 4'd0, 100, 0);
    run_burst(4'd0, 4'd3, 100, 0);
    run_burst(4'd0, 4'd7, 100, 10);
    run_burst(4'd14, 4'd3, 100, 0);

    // Randomized bursts with random downstream stalls.
    for (int k = 0; k < 12; k++) begin
      for (int i = 0; i < 16; i++) mem[i] = $urandom;
      run_burst(AW'($urandom_range(15)), LW'($urandom_range(15)),
                int'($urandom_range(100, 20)), 0);
    end
    check("perr_clean", 64'(protocol_err), 64'(0));

    // Reset in the middle of a long burst discards everything in flight.
    out_ready = 1'b1;
    cmd_valid = 1'b1;
    cmd_addr  = 4'd0;
    cmd_len   = 4'd7;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_out_valid", 64'(out_valid), 64'(0));
    check("midrst_r_avalid",  64'(r_avalid),  64'(0));
    check("midrst_cmd_ready", 64'(cmd_ready), 64'(1));
    repeat (LAT + 2) begin
      @(negedge clk);
      check("midrst_no_stale", 64'(out_valid), 64'(0));
    end
    run_burst(4'd2, 4'd0, 100, 0);

    // Stray read data while idle sets the sticky error and is dropped.
    force_dv = 1'b1;
    @(negedge clk);
    force_dv = 1'b0;
    check("perr_set",       64'(protocol_err), 64'(1));
    check("perr_no_push",   64'(out_valid),    64'(0));
    repeat (3) @(negedge clk);
    check("perr_sticky",    64'(protocol_err), 64'(1));
    check("perr_still_empty", 64'(out_valid),  64'(0));
    run_burst(4'd9, 4'd2, 100, 0);
    check("perr_after_burst", 64'(protocol_err), 64'(1));
    do_reset();
    check_idle("reset2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
